seg_serial_driver: RTL and testbench

SEG_SERIAL_DRIVER -- requirements
Module: seg_serial_driver

---
 rtl/seg_pkg.sv | 54 +++++
 rtl/seg_bin2bcd_seq.sv | 70 +++++++
 rtl/seg_serial_driver.sv | 176 +++++++++++++++++
 tb/tb_seg_serial_driver.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, segment encodings and scan-state type for the serial 7-segment driver.
package seg_pkg;

  localparam int unsigned FRAME_BITS = 16;

  // Active-high segments in gfedcba order.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    SH_LO,
    SH_HI,
    LATCH_HI,
    LATCH_LO
  } scan_state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [31:0] pow10(input int unsigned n);
    logic [31:0] p;
    p = 32'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/seg_bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, overflow flagged when the
// value does not fit in NumDigits decimal digits.
module seg_bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned BinWidth  = 14,
  parameter int unsigned NumDigits = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [BinWidth-1:0]      value_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [4*NumDigits-1:0]   bcd_o,
  output logic                     ovf_o
);

  localparam int unsigned BcdW = 4 * NumDigits;
  localparam int unsigned CntW = $clog2(BinWidth);
  localparam logic [31:0] OvfLimit = pow10(NumDigits);

  logic [BinWidth-1:0] bin_q;
  logic [BcdW-1:0]     bcd_q, bcd_adj;
  logic [CntW-1:0]     cnt_q;
  logic                busy_q, done_q, ovf_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(NumDigits); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i && !busy_q) begin
        bin_q  <= value_i;
        bcd_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
        ovf_q  <= 32'(value_i) >= OvfLimit;
      end else if (busy_q) begin
        bin_q <= bin_q << 1;
        bcd_q <= {bcd_adj[BcdW-2:0], bin_q[BinWidth-1]};
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CntW'(BinWidth - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/seg_serial_driver.sv
// Multiplexed 7-segment driver: converts a binary value to decimal and continuously scans
// 16-bit digit frames out to an external shift register with a latch pulse per digit.
module seg_serial_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BIN_WIDTH  = 14,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [BIN_WIDTH-1:0]  i_value,
  input  logic                  i_load,
  input  logic                  i_blank_lz,
  input  logic [NUM_DIGITS-1:0] i_dp,
  output logic                  o_busy,
  output logic                  o_segClk,
  output logic                  o_segData,
  output logic                  o_segLatch
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BcdW = 4 * NUM_DIGITS;

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  scan_state_e           state_q, state_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [3:0]            bit_q, bit_d;
  logic [2:0]            digit_q, digit_d;
  logic                  div_last, wrap, shift_en, frame_load;
  logic [FRAME_BITS-1:0] frame_q, frame_new;

  digits_t disp_q, pend_q;
  logic    disp_ovf_q, pend_ovf_q, pend_vld_q;

  logic            conv_busy, conv_done, conv_ovf;
  logic [BcdW-1:0] conv_bcd;

  logic [3:0]            cur_digit;
  logic                  cur_dp, cur_blank, zero_above;
  logic [NUM_DIGITS-1:0] lz;
  logic [6:0]            seg;

  seg_bin2bcd_seq #(
    .BinWidth  (BIN_WIDTH),
    .NumDigits (NUM_DIGITS)
  ) u_bin2bcd (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .start_i (i_load),
    .value_i (i_value),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .ovf_o   (conv_ovf)
  );

  assign o_busy     = conv_busy;
  assign div_last   = (div_q == DivW'(CLK_DIV - 1));
  assign frame_load = (state_q == SH_LO) && (bit_q == 4'd0) && (div_q == '0);

  // Frame for the current digit, built from the committed display buffer.
  always_comb begin
    cur_digit  = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    zero_above = 1'b1;
    lz         = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      lz[i]      = zero_above && (disp_q[i] == 4'd0) && (i != 0);
      zero_above = zero_above && (disp_q[i] == 4'd0);
    end
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (digit_q == 3'(i)) begin
        cur_digit = disp_q[i];
        cur_dp    = i_dp[i];
        cur_blank = i_blank_lz && lz[i];
      end
    end
    if (disp_ovf_q)     seg = SEG_DASH;
    else if (cur_blank) seg = SEG_BLANK;
    else                seg = seg_encode(cur_digit);
    frame_new = {cur_dp, seg, 8'b1 << digit_q};
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_last ? '0 : div_q + 1'b1;
    bit_d      = bit_q;
    digit_d    = digit_q;
    wrap       = 1'b0;
    shift_en   = 1'b0;
    o_segClk   = 1'b0;
    o_segLatch = 1'b0;
    o_segData  = 1'b0;
    unique case (state_q)
      SH_LO: begin
        if (div_last) state_d = SH_HI;
      end
      SH_HI: begin
        o_segClk = 1'b1;
        if (div_last) begin
          if (bit_q == 4'(FRAME_BITS - 1)) begin
            state_d = LATCH_HI;
          end else begin
            state_d  = SH_LO;
            bit_d    = bit_q + 4'd1;
            shift_en = 1'b1;
          end
        end
      end
      LATCH_HI: begin
        o_segLatch = 1'b1;
        if (div_last) state_d = LATCH_LO;
      end
      LATCH_LO: begin
        if (div_last) begin
          state_d = SH_LO;
          bit_d   = 4'd0;
          if (digit_q == 3'(NUM_DIGITS - 1)) begin
            digit_d = 3'd0;
            wrap    = 1'b1;
          end else begin
            digit_d = digit_q + 3'd1;
          end
        end
      end
      default: state_d = SH_LO;
    endcase
    // Bit 0 comes straight from the new frame on its load cycle; gated so reset forces 0.
    if (i_rst_n && (state_q == SH_LO || state_q == SH_HI)) begin
      o_segData = frame_load ? frame_new[0] : frame_q[0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SH_LO;
      div_q   <= '0;
      bit_q   <= '0;
      digit_q <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      digit_q <= digit_d;
      if (frame_load)    frame_q <= frame_new;
      else if (shift_en) frame_q <= frame_q >> 1;
    end
  end

  // Pending result is committed only at the digit wrap so no scan mixes old and new digits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
      pend_q     <= '0;
      pend_ovf_q <= 1'b0;
      pend_vld_q <= 1'b0;
    end else begin
      if (wrap && pend_vld_q) begin
        disp_q     <= pend_q;
        disp_ovf_q <= pend_ovf_q;
        pend_vld_q <= 1'b0;
      end
      if (conv_done) begin
        pend_q     <= conv_bcd;
        pend_ovf_q <= conv_ovf;
        pend_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_serial_driver.sv
// Directed bench for seg_serial_driver: captures serial frames off the pins and compares them
// against hand-computed frame words.
module tb_seg_serial_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned BW = 14;
  localparam int unsigned CD = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] value;
  logic          load;
  logic          blank;
  logic [ND-1:0] dp;
  logic          busy, seg_clk, seg_data, seg_latch;

  always #5 clk = ~clk;

  seg_serial_driver #(
    .NUM_DIGITS (ND),
    .BIN_WIDTH  (BW),
    .CLK_DIV    (CD)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_value    (value),
    .i_load     (load),
    .i_blank_lz (blank),
    .i_dp       (dp),
    .o_busy     (busy),
    .o_segClk   (seg_clk),
    .o_segData  (seg_data),
    .o_segLatch (seg_latch)
  );

  int   tests = 0;
  int   fails = 0;
  logic prev_clk = 1'b0;
  int   busy_run = 0;
  int   busy_len = 0;

  typedef struct {
    logic [BW-1:0]      value;
    logic               blank;
    logic [ND-1:0]      dp;
    logic [3:0][15:0]   exp;
  } vec_t;

  vec_t vecs [8];

  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busy_run++;
    end else begin
      if (busy_run != 0) busy_len = busy_run;
      busy_run = 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Records one frame from segClk rising edges, returns once its latch pulse is seen.
  // Optional loads are strobed at the given bit positions.
  task automatic capture_frame(input int lb1, input logic [BW-1:0] v1,
                               input int lb2, input logic [BW-1:0] v2,
                               output logic [15:0] f);
    int n = 0;
    int cyc = 0;
    bit seen = 1'b0;
    f = '0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (load) load = 1'b0;
      if (n < 16 && seg_clk && !prev_clk) begin
        f[n] = seg_data;
        if (n == lb1) begin value = v1; load = 1'b1; end
        if (n == lb2) begin value = v2; load = 1'b1; end
        n++;
      end
      if (n == 16 && seg_latch) seen = 1'b1;
      prev_clk = seg_clk;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL frame_timeout: got %0d bits, expected 16 bits and a latch", n);
    end
  endtask

  task automatic seek_digit0(output logic [15:0] f);
    for (int k = 0; k < 5; k++) begin
      capture_frame(-1, '0, -1, '0, f);
      if (f[7:0] == 8'h01) break;
    end
  endtask

  task automatic check_scan(input string tag, input logic [3:0][15:0] exp);
    logic [15:0] f;
    seek_digit0(f);
    check($sformatf("%s_d0", tag), 64'(f), 64'(exp[0]));
    for (int d = 1; d < 4; d++) begin
      capture_frame(-1, '0, -1, '0, f);
      check($sformatf("%s_d%0d", tag, d), 64'(f), 64'(exp[d]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] f, lo, hi;
    logic [33:0] clkmask, latmask;
    logic [1:0]  latdata;
    int          rises;

    vecs[0] = '{14'd1234,  1'b0, 4'b0000, {16'h0608, 16'h5B04, 16'h4F02, 16'h6601}};
    vecs[1] = '{14'd7,     1'b1, 4'b0100, {16'h0008, 16'h8004, 16'h0002, 16'h0701}};
    vecs[2] = '{14'd10000, 1'b1, 4'b0001, {16'h4008, 16'h4004, 16'h4002, 16'hC001}};
    vecs[3] = '{14'd9999,  1'b1, 4'b0000, {16'h6F08, 16'h6F04, 16'h6F02, 16'h6F01}};
    vecs[4] = '{14'd0,     1'b1, 4'b1111, {16'h8008, 16'h8004, 16'h8002, 16'hBF01}};
    vecs[5] = '{14'd1005,  1'b1, 4'b0000, {16'h0608, 16'h3F04, 16'h3F02, 16'h6D01}};
    vecs[6] = '{14'd60,    1'b1, 4'b0000, {16'h0008, 16'h0004, 16'h7D02, 16'h3F01}};
    vecs[7] = '{14'd16383, 1'b0, 4'b1010, {16'hC008, 16'h4004, 16'hC002, 16'h4001}};

    // Reset state, with a load strobe that must not start a conversion.
    rst_n = 1'b0;
    load  = 1'b1;
    value = 14'd1234;
    blank = 1'b0;
    dp    = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({seg_clk, seg_data, seg_latch, busy}), 64'd0);
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Cycle-exact first frame after reset release.
    for (int j = 0; j < 34; j++) begin
      if (j == 0) #1;
      else @(negedge clk);
      clkmask[j] = seg_clk;
      latmask[j] = seg_latch;
      if (j < 32) begin
        if (j % 2 == 0) lo[j/2] = seg_data;
        else            hi[j/2] = seg_data;
      end else begin
        latdata[j-32] = seg_data;
      end
    end
    check("first_frame_lo", 64'(lo), 64'h3F01);
    check("first_frame_hi", 64'(hi), 64'h3F01);
    check("first_clk_pattern", 64'(clkmask), 64'h0_AAAA_AAAA);
    check("first_latch_pattern", 64'(latmask), 64'h1_0000_0000);
    check("first_latch_data", 64'(latdata), 64'd0);
    prev_clk = 1'b0;
    for (int d = 1; d < 4; d++) begin
      capture_frame(-1, '0, -1, '0, f);
      check($sformatf("zeros_d%0d", d), 64'(f), 64'(16'h3F00 | (16'h1 << d)));
    end

    // Table-driven loads.
    for (int v = 0; v < 8; v++) begin
      blank    = vecs[v].blank;
      dp       = vecs[v].dp;
      busy_len = 0;
      capture_frame(0, vecs[v].value, -1, '0, f);
      check_scan($sformatf("vec%0d", v), vecs[v].exp);
      check($sformatf("vec%0d_busy_len", v), 64'(busy_len), 64'd14);
    end

    // Second load while busy is ignored.
    blank    = 1'b0;
    dp       = '0;
    busy_len = 0;
    capture_frame(0, 14'd5, 3, 14'd9, f);
    check_scan("load5_ign9", {16'h3F08, 16'h3F04, 16'h3F02, 16'h6D01});
    check("load5_busy_len", 64'(busy_len), 64'd14);

    // Load during digit 2: digits 2 and 3 keep old values until the wrap.
    for (int k = 0; k < 5; k++) begin
      capture_frame(-1, '0, -1, '0, f);
      if (f[7:0] == 8'h02) break;
    end
    capture_frame(2, 14'd9876, -1, '0, f);
    check("midscan_d2_old", 64'(f), 64'h3F04);
    capture_frame(-1, '0, -1, '0, f);
    check("midscan_d3_old", 64'(f), 64'h3F08);
    check_scan("new9876", {16'h6F08, 16'h7F04, 16'h0702, 16'h7D01});

    // Reset at bit 7 of digit 1 with one result pending and another conversion running.
    capture_frame(0, 14'd8888, -1, '0, f);
    check("pre_rst_d0", 64'(f), 64'h7D01);
    rises = 0;
    for (int c = 0; c < 60 && rises < 8; c++) begin
      @(negedge clk);
      if (load) load = 1'b0;
      if (seg_clk && !prev_clk) begin
        rises++;
        if (rises == 2) begin value = 14'd4321; load = 1'b1; end
      end
      prev_clk = seg_clk;
    end
    check("rst_point_bits", 64'(rises), 64'd8);
    check("busy_before_rst", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 64'({seg_clk, seg_data, seg_latch, busy}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    prev_clk = 1'b0;
    capture_frame(-1, '0, -1, '0, f);
    check("after_rst_d0", 64'(f), 64'h3F01);
    for (int d = 1; d < 4; d++) begin
      capture_frame(-1, '0, -1, '0, f);
      check($sformatf("after_rst_d%0d", d), 64'(f), 64'(16'h3F00 | (16'h1 << d)));
    end
    capture_frame(-1, '0, -1, '0, f);
    check("after_rst_wrap_d0", 64'(f), 64'h3F01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
